// File: rtl/mips_instr_encoder.sv
// ============================================================================
//  Module   : mips_instr_encoder
//  Purpose  : Encodes compact instruction requests into 32-bit MIPS words and
//             streams them to sequential instruction-memory word addresses.
//             The li pseudo-op is expanded into lui+ori.
//  Config   : LI_SHORT_EN - when defined, li whose upper half is zero emits
//             only a single ori rt,$0,imm.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_out
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LI2  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_out_valid;
    logic [31:0]         r_out_word;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_err;
    logic [31:0]         r_pend_word;

    logic [31:0]         w_word;
    logic [31:0]         w_pend;
    logic                w_illegal;
    logic                w_li_two;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_out_hs;

    // Field encoder: unused fields are zeroed, never passed through.
    always_comb begin
        w_word    = 32'h0;
        w_pend    = {6'h0D, in_rt, in_rt, in_imm[15:0]};
        w_illegal = 1'b0;
        w_li_two  = 1'b0;
        case (in_mnem)
            4'h0: w_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
            4'h1: w_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h02};
            4'h2: w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            4'h3: w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            4'h4: w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            4'h5: w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            4'h6: w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
            4'h7: w_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
            4'h8: w_word = {6'h0A, in_rs, in_rt, in_imm[15:0]};
            4'h9: w_word = {6'h0C, in_rs, in_rt, in_imm[15:0]};
            4'hA: w_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
            4'hB: w_word = {6'h0F, 5'd0, in_rt, in_imm[15:0]};
            4'hC: w_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
            4'hD: w_word = {6'h05, in_rs, in_rt, in_imm[15:0]};
            4'hE: begin
`ifdef LI_SHORT_EN
                if (in_imm[31:16] == 16'h0) begin
                    w_word = {6'h0D, 5'd0, in_rt, in_imm[15:0]};
                end else begin
                    w_word   = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
                    w_li_two = 1'b1;
                end
`else
                w_word   = {6'h0F, 5'd0, in_rt, in_imm[31:16]};
                w_li_two = 1'b1;
`endif
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = !reset && (r_state == S_IDLE) && (!r_out_valid || out_ready);
        w_accept     = in_valid && w_in_ready;
        w_out_hs     = r_out_valid && out_ready;
        case (r_state)
            S_IDLE:  if (w_accept && w_li_two) w_state_next = S_LI2;
            S_LI2:   if (w_out_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_word  <= 32'h0;
            r_out_addr  <= ADDR_W'(BASE_ADDR);
            r_err       <= 1'b0;
            r_pend_word <= 32'h0;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_out_hs) begin
                r_out_addr <= r_out_addr + 1'b1;
            end
            // The ori half follows the lui handshake on the same edge, no bubble.
            if ((r_state == S_LI2) && w_out_hs) begin
                r_out_word  <= r_pend_word;
                r_out_valid <= 1'b1;
            end else if (w_accept && !w_illegal) begin
                r_out_word  <= w_word;
                r_out_valid <= 1'b1;
                if (w_li_two) begin
                    r_pend_word <= w_pend;
                end
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_addr  = r_out_addr;
    assign err_out   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
// ============================================================================
//  Module   : tb_mips_instr_encoder
//  Purpose  : Self-checking bench for mips_instr_encoder (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_mnem = 4'h0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic [31:0] in_imm = 32'h0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, err_out;
    logic [31:0] out_word;
    logic [7:0]  out_addr;

    logic        w2_in_ready, w2_out_valid, w2_err;
    logic [31:0] w2_out_word;
    logic [1:0]  w2_out_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .err_out(err_out)
    );

    mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w2_in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .out_valid(w2_out_valid),
        .out_ready(out_ready), .out_word(w2_out_word), .out_addr(w2_out_addr),
        .err_out(w2_err)
    );

    // Reference encoding built arithmetically from the field positions.
    function automatic logic [31:0] rfmt(input int rs, input int rt, input int rd,
                                         input int sh, input int fn);
        longint v;
        v = rs * 2**21 + rt * 2**16 + rd * 2**11 + sh * 64 + fn;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ifmt(input int op, input int rs, input int rt,
                                         input int imm16);
        longint v;
        v = longint'(op) * 2**26 + rs * 2**21 + rt * 2**16 + imm16;
        return v[31:0];
    endfunction

    function automatic int model(input logic [3:0] m, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] sh, input logic [31:0] imm,
                                 output logic [31:0] w0, output logic [31:0] w1);
        int lo, hi;
        int funcs[7] = '{0, 2, 32, 34, 36, 37, 42};
        int ops[7]   = '{8, 10, 12, 13, 15, 4, 5};
        lo = int'(imm % 65536);
        hi = int'(imm / 65536);
        w0 = 32'h0;
        w1 = 32'h0;
        if (m <= 4'h1) begin
            w0 = rfmt(0, rt, rd, sh, funcs[m]);
            return 1;
        end else if (m <= 4'h6) begin
            w0 = rfmt(rs, rt, rd, 0, funcs[m]);
            return 1;
        end else if (m <= 4'hD) begin
            w0 = ifmt(ops[m - 7], (m == 4'hB) ? 0 : int'(rs), rt, lo);
            return 1;
        end else if (m == 4'hE) begin
`ifdef LI_SHORT_EN
            if (hi == 0) begin
                w0 = ifmt(13, 0, rt, lo);
                return 1;
            end
`endif
            w0 = ifmt(15, 0, rt, hi);
            w1 = ifmt(13, rt, rt, lo);
            return 2;
        end
        return 0;
    endfunction

    task automatic set_req(input logic v, input logic [3:0] m, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [31:0] imm);
        in_valid = v; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_req(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        set_req(1'b1, 4'h7, 5'd0, 5'd8, 5'd0, 5'd0, 32'h5);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_word !== 32'h0 || out_addr !== 8'h0 ||
            err_out !== 1'b0 || in_ready !== 1'b0 || w2_out_addr !== 2'd0) begin
            failures++;
            $display("FAIL reset: valid=%b word=%h addr=%h err=%b rdy=%b want 0,0,0,0,0",
                     out_valid, out_word, out_addr, err_out, in_ready);
        end
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0]  m[4]   = '{4'h7, 4'h0, 4'h8, 4'hC};
        logic [4:0]  rs[4]  = '{5'd0, 5'd0, 5'd8, 5'd8};
        logic [4:0]  rt[4]  = '{5'd8, 5'd8, 5'd9, 5'd9};
        logic [4:0]  rd[4]  = '{5'd0, 5'd9, 5'd0, 5'd0};
        logic [4:0]  sh[4]  = '{5'd0, 5'd2, 5'd0, 5'd0};
        logic [31:0] im[4]  = '{32'h5, 32'h0, 32'hFFFF, 32'hFFFE};
        logic [31:0] exp[4] = '{32'h20080005, 32'h00084880, 32'h2909FFFF, 32'h1109FFFE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, m[i], rs[i], rt[i], rd[i], sh[i], im[i]);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_word !== exp[i] || out_addr !== 8'(i)) begin
                failures++;
                $display("FAIL basic[%0d]: valid=%b word=%h addr=%0d want 1 %h %0d",
                         i, out_valid, out_word, out_addr, exp[i], i);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 8'd4) begin
            failures++;
            $display("FAIL basic_drain: valid=%b addr=%0d want 0 4", out_valid, out_addr);
        end
    endtask

    task automatic test_li();
        do_reset();
        set_req(1'b1, 4'hE, 5'd3, 5'd8, 5'd0, 5'd0, 32'h12345678);
        @(negedge clk);
        set_req(1'b1, 4'h7, 5'd0, 5'd8, 5'd0, 5'd0, 32'h5);
        #1;
        checks++;
        if (out_word !== 32'h3C081234 || out_addr !== 8'd0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL li_lui: word=%h addr=%0d rdy=%b want 3c081234 0 0",
                     out_word, out_addr, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h35085678 || out_addr !== 8'd1) begin
            failures++;
            $display("FAIL li_ori: valid=%b word=%h addr=%0d want 1 35085678 1",
                     out_valid, out_word, out_addr);
        end
        @(negedge clk);
        checks++;
        if (out_word !== 32'h20080005 || out_addr !== 8'd2) begin
            failures++;
            $display("FAIL li_follow: word=%h addr=%0d want 20080005 2", out_word, out_addr);
        end
        set_req(1'b1, 4'hE, 5'd0, 5'd8, 5'd0, 5'd0, 32'h42);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
`ifdef LI_SHORT_EN
        if (out_word !== 32'h34080042 || out_addr !== 8'd3) begin
`else
        if (out_word !== 32'h3C080000 || out_addr !== 8'd3) begin
`endif
            failures++;
            $display("FAIL li_small_first: word=%h addr=%0d", out_word, out_addr);
        end
        @(negedge clk);
        checks++;
`ifdef LI_SHORT_EN
        if (out_valid !== 1'b0) begin
`else
        if (out_valid !== 1'b1 || out_word !== 32'h35080042 || out_addr !== 8'd4) begin
`endif
            failures++;
            $display("FAIL li_small_second: valid=%b word=%h addr=%0d",
                     out_valid, out_word, out_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(1'b1, 4'h2, 5'd1, 5'd2, 5'd3, 5'd7, 32'h0);
        @(negedge clk);
        out_ready = 1'b0;
        set_req(1'b1, 4'h5, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_word !== 32'h00221820 || out_addr !== 8'd0 ||
                in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall[%0d]: valid=%b word=%h addr=%0d rdy=%b want 1 00221820 0 0",
                         i, out_valid, out_word, out_addr, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_word !== 32'h00853025 || out_addr !== 8'd1) begin
            failures++;
            $display("FAIL stall_release: word=%h addr=%0d want 00853025 1", out_word, out_addr);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_req(1'b1, 4'hF, 5'd1, 5'd2, 5'd3, 5'd4, 32'hFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (err_out !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse: err=%b valid=%b want 1 0", err_out, out_valid);
        end
        set_req(1'b1, 4'h7, 5'd0, 5'd8, 5'd0, 5'd0, 32'h5);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (err_out !== 1'b0 || out_word !== 32'h20080005 || out_addr !== 8'd0) begin
            failures++;
            $display("FAIL illegal_after: err=%b word=%h addr=%0d want 0 20080005 0",
                     err_out, out_word, out_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(1'b1, 4'h7, 5'd0, 5'd8, 5'd0, 5'd0, 32'h5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (w2_out_valid !== 1'b1 || w2_out_addr !== 2'(i % 4)) begin
                failures++;
                $display("FAIL wrap[%0d]: valid=%b addr=%0d want 1 %0d",
                         i, w2_out_valid, w2_out_addr, i % 4);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_li2();
        do_reset();
        set_req(1'b1, 4'h5, 5'd1, 5'd1, 5'd1, 5'd0, 32'h0);
        @(negedge clk);
        set_req(1'b1, 4'hE, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_li2: valid=%b addr=%0d want 0 0", out_valid, out_addr);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_li2_drop: valid=%b word=%h want 0", out_valid, out_word);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] w0, w1;
        logic [7:0]  exp_addr = 8'd0;
        logic        exp_err = 1'b0;
        logic        acc, hs, exp_rdy;
        int          n;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++;
            if (out_valid !== (q.size() > 0) || err_out !== exp_err ||
                (q.size() > 0 && (out_word !== q[0] || out_addr !== exp_addr))) begin
                failures++;
                $display("FAIL random_out[%0d]: valid=%b word=%h addr=%0d err=%b want %b %h %0d %b",
                         cyc, out_valid, out_word, out_addr, err_out, q.size() > 0,
                         (q.size() > 0) ? q[0] : 32'h0, exp_addr, exp_err);
            end
            set_req(($urandom % 4) != 0, 4'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom),
                    ($urandom % 3 == 0) ? ($urandom % 65536) : $urandom);
            out_ready = ($urandom % 3) != 0;
            #1;
            exp_rdy = (q.size() < 2) && ((q.size() == 0) || out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL random_ready[%0d]: rdy=%b want %b", cyc, in_ready, exp_rdy);
            end
            acc = in_valid && exp_rdy;
            hs  = (q.size() > 0) && out_ready;
            @(posedge clk);
            if (hs) begin
                void'(q.pop_front());
                exp_addr++;
            end
            exp_err = acc && (in_mnem == 4'hF);
            if (acc) begin
                n = model(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, w0, w1);
                if (n >= 1) q.push_back(w0);
                if (n == 2) q.push_back(w1);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_li();
        test_stall();
        test_illegal();
        test_wrap();
        test_reset_li2();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
